// File: rtl/rr_pkg.sv
// Shared definitions for the 4-way round-robin arbiter and its ingress request queue.
package rr_pkg;

    localparam int N_REQ = 4;
    localparam int SRC_W = 2;

    // Arbiter state encodings: idle, then "requester k granted last".
    localparam logic [2:0] si = 3'd0;
    localparam logic [2:0] s0 = 3'd1;
    localparam logic [2:0] s1 = 3'd2;
    localparam logic [2:0] s2 = 3'd3;
    localparam logic [2:0] s3 = 3'd4;

    typedef struct packed {
        logic             vld;
        logic [SRC_W-1:0] idx;
    } oh_t;

    // vld is set only for an exactly one-hot grant; idx is meaningful only then.
    function automatic oh_t onehot_idx(input logic [N_REQ-1:0] gnt);
        oh_t res;
        res.vld = $onehot(gnt);
        res.idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) res.idx = SRC_W'(k);
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_fifo.sv
// Single-clock FIFO with combinational head and occupancy count; only control state is reset.
module rr_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                   c,
    input  logic                   r,
    input  logic                   push,
    input  logic [DW-1:0]          wdata,
    input  logic                   pop,
    output logic [DW-1:0]          rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = push && (r_count != CNT_FULL);
    assign w_pop  = pop && (r_count != '0);

    always_ff @(posedge c) begin
        if (w_push) r_mem[r_wptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rptr];
    assign count = r_count;

endmodule

// File: rtl/rr_req_queue.sv
// Per-requester ingress FIFOs feeding the round-robin arbiter: request masking,
// grant decode, popped-word output register and ignored-grant counter.
module rr_req_queue
    import rr_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                  c,
    input  logic                  r,
    input  logic [N_REQ-1:0]      in_valid,
    input  logic [N_REQ*DW-1:0]   in_data,
    output logic [N_REQ-1:0]      in_ready,
    output logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      gnt,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    output logic [SRC_W-1:0]      out_src,
    output logic [7:0]            gnt_miss
);

    localparam int           CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0]    w_count [N_REQ];
    logic [DW-1:0]    w_head  [N_REQ];
    logic [N_REQ-1:0] w_push;
    logic [N_REQ-1:0] w_pop;
    oh_t              w_oh;
    logic             w_take;
    logic             w_miss;

    logic             r_out_valid;
    logic [DW-1:0]    r_out_data;
    logic [SRC_W-1:0] r_out_src;
    logic [7:0]       r_gnt_miss;

    assign w_oh   = onehot_idx(gnt);
    assign w_take = w_oh.vld && (w_count[w_oh.idx] != '0);
    assign w_miss = (gnt != '0) && !w_take;

    // A granted queue holding its last word drops its request so it is not re-granted empty.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_fifo
        assign in_ready[gi] = (w_count[gi] != CNT_FULL);
        assign w_push[gi]   = in_valid[gi] && in_ready[gi];
        assign w_pop[gi]    = w_take && (w_oh.idx == SRC_W'(gi));
        assign req[gi]      = gnt[gi] ? (w_count[gi] > CNT_ONE) : (w_count[gi] != '0);

        rr_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .c     (c),
            .r     (r),
            .push  (w_push[gi]),
            .wdata (in_data[gi*DW +: DW]),
            .pop   (w_pop[gi]),
            .rdata (w_head[gi]),
            .count (w_count[gi])
        );
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_gnt_miss  <= '0;
        end else begin
            r_out_valid <= w_take;
            if (w_take) begin
                r_out_data <= w_head[w_oh.idx];
                r_out_src  <= w_oh.idx;
            end
            if (w_miss && (r_gnt_miss != 8'hFF)) r_gnt_miss <= r_gnt_miss + 8'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign gnt_miss  = r_gnt_miss;

endmodule

// File: tb/tb_rr_req_queue.sv
// Bench for rr_req_queue: queue-based reference model plus a behavioural round-robin arbiter.
module tb_rr_req_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic        c = 1'b0;
    logic        r;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic [7:0]  gnt_miss;

    always #5 c = ~c;

    rr_req_queue #(.DW(DW), .DEPTH(DEPTH)) dut (
        .c         (c),
        .r         (r),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .gnt_miss  (gnt_miss)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] mq [4][$];
    int         miss;
    bit         ev;
    logic [7:0] eo;
    int         es;
    bit         use_arb = 1'b0;
    logic [3:0] arb_gnt;
    int         arb_last;
    logic [3:0] req_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        miss     = 0;
        ev       = 1'b0;
        arb_gnt  = '0;
        arb_last = 3;
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model at posedge, check registers.
    task automatic cyc(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g);
        logic [3:0] ge;
        logic [3:0] exp_req;
        logic [3:0] exp_rdy;
        int         idx;
        int         j;
        bit         take;
        @(negedge c);
        ge       = use_arb ? arb_gnt : g;
        in_valid = v;
        in_data  = d;
        gnt      = ge;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_rdy[i] = (mq[i].size() < DEPTH);
            exp_req[i] = ge[i] ? (mq[i].size() > 1) : (mq[i].size() > 0);
        end
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("req", 32'(req), 32'(exp_req));
        req_s = req;
        @(posedge c);
        if (!r) begin
            model_reset();
        end else begin
            take = 1'b0;
            idx  = 0;
            if ($countones(ge) == 1) begin
                for (int i = 0; i < 4; i++) if (ge[i]) idx = i;
                take = (mq[idx].size() > 0);
            end
            if (take) begin
                eo = mq[idx].pop_front();
                es = idx;
            end
            ev = take;
            if (ge != 4'b0 && !take && miss < 255) miss++;
            for (int i = 0; i < 4; i++)
                if (v[i] && exp_rdy[i]) mq[i].push_back(d[i*8 +: 8]);
            arb_gnt = '0;
            if (use_arb) begin
                for (int k = 1; k <= 4; k++) begin
                    j = (arb_last + k) % 4;
                    if (req_s[j]) begin
                        arb_gnt  = 4'(1 << j);
                        arb_last = j;
                        break;
                    end
                end
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("gnt_miss", 32'(gnt_miss), 32'(miss));
        if (ev) begin
            chk("out_data", 32'(out_data), 32'(eo));
            chk("out_src", 32'(out_src), 32'(es));
        end
    endtask

    initial begin
        int k;
        int m0;
        int tgt;
        int total;
        logic [3:0] g;

        r        = 1'b1;
        in_valid = '0;
        in_data  = '0;
        gnt      = '0;
        model_reset();
        #2 r = 1'b0;

        // Reset values under random inputs
        for (int n = 0; n < 3; n++) cyc(4'($urandom), $urandom, 4'($urandom));
        chk("t1_ready", 32'(in_ready), 32'hF);
        r = 1'b1;

        // Single-entry request mask
        cyc(4'b0100, 32'h00A5_0000, 4'b0000);
        chk("t2_req1", 32'(req), 32'b0100);
        cyc(4'b0000, 32'h0, 4'b0100);
        chk("t2_ov", 32'(out_valid), 32'h1);
        chk("t2_data", 32'(out_data), 32'hA5);
        chk("t2_src", 32'(out_src), 32'h2);
        cyc(4'b0000, 32'h0, 4'b0100);
        chk("t2_req0", 32'(req), 32'h0);
        chk("t2_miss", 32'(gnt_miss), 32'h1);

        // Round-robin drain through the behavioural arbiter
        for (int j = 0; j < 4; j++)
            cyc(4'hF, {8'(8'h30 + j), 8'(8'h20 + j), 8'(8'h10 + j), 8'(j)}, 4'b0);
        use_arb = 1'b1;
        k = 0;
        for (int n = 0; n < 24; n++) begin
            cyc(4'b0, 32'h0, 4'b0);
            if (ev) begin
                chk("t3_src", 32'(out_src), 32'(k % 4));
                chk("t3_data", 32'(out_data), 32'((k % 4) * 16 + k / 4));
                k++;
            end
        end
        chk("t3_count", 32'(k), 32'd16);
        use_arb = 1'b0;

        // Full FIFO, then simultaneous push/pop across pointer wrap
        for (int j = 0; j < 4; j++) cyc(4'b0001, 32'(8'h10 + j), 4'b0);
        chk("t4_full", 32'(in_ready[0]), 32'h0);
        k = 0;
        cyc(4'b0, 32'h0, 4'b0001);
        chk("t4_order", 32'(out_data), 32'(8'h10 + k)); k++;
        for (int j = 4; j < 10; j++) begin
            cyc(4'b0001, 32'(8'h10 + j), 4'b0001);
            chk("t4_order", 32'(out_data), 32'(8'h10 + k)); k++;
        end
        for (int j = 0; j < 3; j++) begin
            cyc(4'b0, 32'h0, 4'b0001);
            chk("t4_ov", 32'(out_valid), 32'h1);
            chk("t4_order", 32'(out_data), 32'(8'h10 + k)); k++;
        end

        // Multi-hot grants are ignored and counted with saturation
        cyc(4'b0011, 32'h0000_5251, 4'b0);
        m0 = miss;
        cyc(4'b0, 32'h0, 4'b0011);
        chk("t5_ov", 32'(out_valid), 32'h0);
        chk("t5_miss", 32'(gnt_miss), 32'(m0 + 1));
        cyc(4'b0, 32'h0, 4'b0);
        chk("t5_req", 32'(req), 32'b0011);
        for (int n = 0; n < 300; n++) cyc(4'b0, 32'h0, 4'b0011);
        chk("t5_sat", 32'(gnt_miss), 32'd255);
        cyc(4'b0, 32'h0, 4'b0001);
        chk("t5_pop0", 32'(out_data), 32'h51);
        cyc(4'b0, 32'h0, 4'b0010);
        chk("t5_pop1", 32'(out_data), 32'h52);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(3))
                0:       g = 4'b0;
                1, 2:    g = 4'(1 << $urandom_range(3));
                default: g = 4'($urandom);
            endcase
            cyc(4'($urandom), $urandom, g);
        end

        // Drain, then reset mid-operation with three words queued
        for (int n = 0; n < 40; n++) begin
            tgt = -1;
            for (int i = 0; i < 4; i++) if (tgt < 0 && mq[i].size() > 0) tgt = i;
            if (tgt < 0) break;
            cyc(4'b0, 32'h0, 4'(1 << tgt));
        end
        total = 0;
        for (int i = 0; i < 4; i++) total += mq[i].size();
        chk("t6_drained", 32'(total), 32'h0);
        for (int j = 0; j < 4; j++) cyc(4'b0010, 32'(8'h60 + j) << 8, 4'b0);
        cyc(4'b0, 32'h0, 4'b0010);
        chk("t6_pre_ov", 32'(out_valid), 32'h1);
        chk("t6_pre_data", 32'(out_data), 32'h60);
        #2 r = 1'b0;
        #1;
        chk("t6_async_ov", 32'(out_valid), 32'h0);
        chk("t6_async_req", 32'(req), 32'h0);
        chk("t6_async_rdy", 32'(in_ready), 32'hF);
        model_reset();
        cyc(4'b0010, 32'h0000_7700, 4'b0010);
        r = 1'b1;
        cyc(4'b0, 32'h0, 4'b0);
        chk("t6_req_rel", 32'(req), 32'h0);
        chk("t6_miss_rel", 32'(gnt_miss), 32'h0);
        cyc(4'b0010, 32'h0000_3C00, 4'b0);
        cyc(4'b0, 32'h0, 4'b0010);
        chk("t6_ov", 32'(out_valid), 32'h1);
        chk("t6_data", 32'(out_data), 32'h3C);
        chk("t6_src", 32'(out_src), 32'h1);
        cyc(4'b0, 32'h0, 4'b0);
        chk("t6_alone", 32'(out_valid), 32'h0);
        chk("t6_req_end", 32'(req), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_req_queue.md
# rr_req_queue

Per-requester ingress buffer that feeds the 4-way fixed-slice round-robin arbiter. Four independent producers push words into private FIFOs; the block drives the arbiter's `req` vector from FIFO occupancy, consumes its one-hot `gnt`, pops the granted FIFO and presents the word, tagged with its source index, on a single shared output.

## Interface
- `DW`, 8: data word width.
- `DEPTH`, 4: entries per FIFO, power of two, at least 2.
- `N_REQ`, 4: requester count. Fixed at 4 to match the arbiter.

- `c`  in  1  clock; all state updates on the rising edge.
- `r`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  4  per-requester push strobe.
- `in_data`  in  4*DW  push data; requester i on bits `[i*DW +: DW]`.
- `in_ready`  out  4  FIFO i can accept a word.
- `req`  out  4  request vector to the arbiter.
- `gnt`  in  4  grant from the arbiter; one-hot or zero.
- `out_valid`  out  1  `out_data`/`out_src` valid this cycle.
- `out_data`  out  DW  popped word.
- `out_src`  out  2  index of the FIFO the word came from.
- `gnt_miss`  out  8  saturating count of ignored grants.

## Operation
- **Push:** FIFO i accepts a word when `in_valid[i] && in_ready[i]`. `in_ready[i] = (count_i != DEPTH)`. It is computed from current occupancy only; a same-cycle pop does not raise it.
- **Request generation (combinational from state and `gnt`):**
  - `req[i] = (count_i > 1)` when `gnt[i]`; otherwise `req[i] = (count_i != 0)`.
  - This stops the arbiter from re-granting a queue whose last entry is being popped this cycle.
- **Pop:** taken when `gnt` is one-hot, `gnt[i]` is set and `count_i != 0`. On that edge:
  - `out_data <= head_i`, `out_src <= i`, `out_valid <= 1`.
  - Pointers and count of FIFO i update.
- **Ignored grant:** `gnt` is multi-hot, or grants an empty FIFO.
  - No pop; `out_valid <= 0`.
  - `gnt_miss` increments, saturating at 255.
- **Idle:** `gnt == 0` gives `out_valid <= 0` and no miss.
- **Same-FIFO push and pop:** both happen on one edge; count is unchanged. Push into a full FIFO cannot occur (`in_ready` low).
- **Ordering:** each FIFO is strict FIFO. Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Count is `$clog2(DEPTH)+1` bits, range 0..DEPTH.
- **No downstream backpressure:** one word leaves per granted cycle.

## Timing
- **Reset (asynchronous assert, synchronous-to-`c` release):**
  - All counts and pointers are 0.
  - `out_valid=0`, `out_data=0`, `out_src=0`, `gnt_miss=0`.
  - `in_ready=4'hF`, `req=4'h0`.
- **Latency to an empty FIFO:**
  - Push accepted at edge E0.
  - `req[i]` rises after E0.
  - Arbiter registers it at E1; `gnt[i]` is high during cycle E1..E2.
  - Pop at E2; `out_valid` is high during E2..E3.
  - Total: 2 edges from push to output.
- **Steady state:** one output word per cycle while any FIFO is non-empty and the arbiter grants.
- **Reset mid-operation:** all queued data is discarded immediately. `out_valid` drops asynchronously. No pop or push completes on the edge at which `r` is low.
- FIFO storage needs no reset; only its control state does.

## Structure
- **Package `rr_pkg`:**
  - `N_REQ=4`, `SRC_W=2`.
  - Arbiter state encodings: `si`, `s0`..`s3`.
  - Function `onehot_idx(gnt)` returning the index and a valid flag.
  - The arbiter and this block both import it.
- **Sub-module `rr_fifo`** (DW, DEPTH), instantiated N_REQ times:
  - Ports: `c`, `r`, `push`, `wdata`, `pop`, `rdata` (head, combinational), `count`.
- **Top level:** the `req` mask, grant decode, output register and `gnt_miss` counter.

## Test plan
1. **Reset values:** hold `r=0` for 3 cycles with random `in_valid`/`gnt`. Require `out_valid=0`, `req=0`, `in_ready=F`, `gnt_miss=0` throughout.
2. **Single-entry mask:** push 0xA5 to FIFO 2 only. Require `req=4'b0100` one cycle. Drive `gnt=4'b0100` for two cycles:
   - First cycle: `out_valid=1`, `out_data=A5`, `out_src=2`.
   - Second cycle: `req=0`, and `gnt_miss=1`.
3. **Round-robin drain:** fill every FIFO i with words `{i,0}..{i,3}` and connect the real arbiter. Require the output source sequence 0,1,2,3,0,1,… and per-source words in push order, 16 words total.
4. **Full and wrap:** push 4 words into FIFO 0. Require `in_ready[0]=0`. Then pop 1 and push 1 on the same edge, 6 times. Require the popped data in exact push order across pointer wrap.
5. **Multi-hot grant:** drive `gnt=4'b0011` with FIFOs 0 and 1 non-empty. Require no pop, `out_valid=0`, counts unchanged, `gnt_miss` +1. Drive 300 such cycles and require `gnt_miss` to hold at 255.
6. **Reset mid-operation:** assert `r=0` mid-drain with 3 words queued. Require `out_valid` low immediately and `req=0` after release. A subsequent push of 0x3C emerges alone on the output.
